// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage mips32 pipeline: RAW interlock without
// forwarding, taken-branch squash, HLT drain/freeze, and a stall watchdog.
module pipe_hazard_ctrl #(
   parameter int MAX_STALL = 8,
   parameter int DRAIN_CYC = 3,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      id_ir,
   input  logic [31:0]      ex_ir,
   input  logic [31:0]      mem_ir,
   input  logic [31:0]      wb_ir,
   input  logic             mem_cond,
   input  logic             resume,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             halted,
   output logic             stall_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   // state      | meaning
   // S_RUN      | normal issue
   // S_STALL    | RAW interlock, IF/ID frozen, bubbles into EX
   // S_DRAIN    | HLT in decode, older instructions retiring
   // S_HALTED   | frozen until resume pulse
   typedef enum logic [1:0] {S_RUN, S_STALL, S_DRAIN, S_HALTED} state_t;

   localparam int SW = $clog2(MAX_STALL + 1);
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [SW-1:0] C_MAX   = SW'(MAX_STALL);
   localparam logic [DW-1:0] C_DRAIN = DW'(DRAIN_CYC - 1);

   function automatic logic [4:0] f_dst(input logic [31:0] ir);
      logic [5:0] op;
      op = ir[31:26];
      if (op <= 6'd4) return ir[15:11];
      if (op == 6'h08 || op == 6'h0A || op == 6'h0B || op == 6'h0C) return ir[20:16];
      return 5'd0;
   endfunction

   function automatic logic f_match(input logic [4:0] src, input logic [4:0] d0,
                                    input logic [4:0] d1, input logic [4:0] d2);
      return (src != 5'd0) && (src == d0 || src == d1 || src == d2);
   endfunction

   state_t         r_state, w_state_nxt;
   logic [SW-1:0]  r_cons, w_cons_nxt;
   logic [DW-1:0]  r_drain, w_drain_nxt;
   logic           r_err;
   logic [CNT_W-1:0] r_scnt, r_fcnt;

   logic [5:0] w_op_id, w_op_mem;
   logic [4:0] w_d_ex, w_d_mem, w_d_wb;
   logic       w_rs_used, w_rt_used, w_hazard, w_taken, w_inc_s, w_inc_f;

   always_comb begin
      w_op_id   = id_ir[31:26];
      w_op_mem  = mem_ir[31:26];
      w_d_ex    = f_dst(ex_ir);
      w_d_mem   = f_dst(mem_ir);
      w_d_wb    = f_dst(wb_ir);
      w_rs_used = (w_op_id <= 6'd4) || (w_op_id >= 6'h08 && w_op_id <= 6'h0E);
      w_rt_used = (w_op_id <= 6'd4) || (w_op_id == 6'h09);
      w_hazard  = (w_rs_used && f_match(id_ir[25:21], w_d_ex, w_d_mem, w_d_wb)) ||
                  (w_rt_used && f_match(id_ir[20:16], w_d_ex, w_d_mem, w_d_wb));
      w_taken   = mem_cond && (w_op_mem == 6'h0D || w_op_mem == 6'h0E || w_op_mem == 6'h10);
   end

   always_comb begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      w_state_nxt  = r_state;
      w_cons_nxt   = r_cons;
      w_drain_nxt  = r_drain;
      w_inc_s      = 1'b0;
      w_inc_f      = 1'b0;
      if (r_state == S_HALTED) begin
         pc_we        = 1'b0;
         if_id_we     = resume;
         if_id_flush  = resume;
         id_ex_bubble = 1'b1;
         if (resume) w_state_nxt = S_RUN;
      end else if (w_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         w_inc_f      = 1'b1;
         w_state_nxt  = S_RUN;
         w_cons_nxt   = '0;
      end else if (r_state == S_DRAIN) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_bubble = 1'b1;
         if (r_drain == '0) w_state_nxt = S_HALTED;
         else               w_drain_nxt = r_drain - DW'(1);
      end else if (w_hazard) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_bubble = 1'b1;
         w_inc_s      = 1'b1;
         w_state_nxt  = S_STALL;
         if (r_state != S_STALL) w_cons_nxt = SW'(1);
         else if (r_cons != C_MAX) w_cons_nxt = r_cons + SW'(1);
      end else begin
         w_cons_nxt  = '0;
         w_state_nxt = S_RUN;
         if (w_op_id == 6'h3F) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            w_drain_nxt  = C_DRAIN;
            w_state_nxt  = S_DRAIN;
         end
      end
      // In reset the datapath must see a frozen PC and a zeroed IF_ID/ID_EX.
      if (!rst_n) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_cons  <= '0;
         r_drain <= '0;
         r_err   <= 1'b0;
         r_scnt  <= '0;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cons  <= w_cons_nxt;
         r_drain <= w_drain_nxt;
         if (w_cons_nxt >= C_MAX) r_err <= 1'b1;
         if (w_inc_s && !(&r_scnt)) r_scnt <= r_scnt + CNT_W'(1);
         if (w_inc_f && !(&r_fcnt)) r_fcnt <= r_fcnt + CNT_W'(1);
      end
   end

   assign halted    = (r_state == S_HALTED);
   assign stall_err = r_err;
   assign stall_cnt = r_scnt;
   assign flush_cnt = r_fcnt;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage mips32 datapath (IF, ID, EX, MEM, WB).
- Watches the IR in each pipeline register and the EX_MEM branch condition, then drives the PC/IF_ID write enables, the ID_EX bubble and the IF_ID flush.
- Resolves RAW hazards by stalling (no forwarding), squashes wrong-path instructions on taken branches, and sequences a HLT drain/freeze.
- Sits beside the datapath; the datapath gates its existing pipeline-register updates with these outputs.

Parameters:
- MAX_STALL, 8, consecutive stall cycles after which stall_err is set (sticky).
- DRAIN_CYC, 3, cycles spent in HALT_DRAIN (EX, MEM, WB retire).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ir  in  32  IF_ID_IR (instruction in decode).
- ex_ir  in  32  ID_EX_IR.
- mem_ir  in  32  EX_MEM_IR.
- wb_ir  in  32  MEM_WB_IR.
- mem_cond  in  1  EX_MEM_Cond.
- resume  in  1  single-cycle pulse; HALTED -> RUN.
- pc_we  out  1  PC update enable.
- if_id_we  out  1  IF_ID register load enable.
- if_id_flush  out  1  load IF_ID_IR with 32'h0 instead of fetched word.
- id_ex_bubble  out  1  load ID_EX_IR with 32'h0, A/B/Imm don't-care.
- halted  out  1  high in HALTED.
- stall_err  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- flush_cnt  out  CNT_W  total taken-branch flushes, saturating.

Behaviour:
- Opcode decode on IR[31:26]:
  - 000000-000100: R-type; sources rs[25:21] and rt[20:16]; destination rd[15:11].
  - 001000 LW, 001010 ADDI, 001011 SUBI, 001100 SLTI: source rs; destination rt.
  - 001001 SW: sources rs and rt; no destination.
  - 001101 BNEQZ, 001110 BEQZ: source rs; no destination.
  - 010000 J: no sources, no destination.
  - 111111 HLT: no sources, no destination.
  - Any other opcode: no sources, no destination.
- Register 0 never creates a hazard. A 32'h0 IR is a benign bubble.
- hazard (comb.): some id_ir source equals a non-zero destination of ex_ir, mem_ir or wb_ir. WB is included because the register bank write is not guaranteed to precede the ID read.
- taken (comb.): mem_cond and mem_ir is BNEQZ, BEQZ or J.
- Output priority (comb. from inputs and state): taken > hazard > HLT.
- taken, any state except HALTED:
  - pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1.
  - flush_cnt++; next state RUN (this aborts HALT_DRAIN and clears the stall run).
- States: RUN, STALL, HALT_DRAIN, HALTED. Reset state RUN.
- RUN:
  - hazard: pc_we=0, if_id_we=0, id_ex_bubble=1, stall_cnt++, go STALL.
  - id_ir is HLT: pc_we=0, if_id_we=0, id_ex_bubble=1, drain counter = DRAIN_CYC-1, go HALT_DRAIN.
  - otherwise: pc_we=1, if_id_we=1, all else 0.
- STALL:
  - While hazard: same freeze outputs, stall_cnt++, consecutive-stall counter ++.
  - When consecutive count reaches MAX_STALL, stall_err<=1.
  - hazard clear: behave exactly as RUN for this cycle (including HLT detection), clear consecutive count.
- HALT_DRAIN:
  - Freeze outputs (pc_we=0, if_id_we=0, id_ex_bubble=1).
  - Drain counter decrements; at 0 go HALTED. Hazards are ignored in this state.
- HALTED:
  - pc_we=0, if_id_we=0, id_ex_bubble=1, halted=1.
  - resume: next state RUN with if_id_flush=1 that cycle, so the HLT is squashed and fetch continues from the current PC.
  - mem_cond is ignored.
- Counters saturate at all-ones.
- Reset, asynchronous, any time including mid-stall or mid-drain:
  - state RUN, all counters 0, stall_err 0, halted 0.
  - While rst_n=0, combinational outputs are forced to pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1.
- Latency: stall, flush and bubble outputs are combinational, zero-cycle. State, flags and counters update on the next edge.

Test Plan:
- ADDI r1 in ex_ir, id_ir = ADD r3,r1,r2 -> 3 consecutive stall cycles as the producer moves EX->MEM->WB; pc_we=0 for those 3 cycles; stall_cnt=3; RUN resumes on the 4th cycle.
- id_ir = ADD r3,r0,r0 with ex_ir writing r0 -> no stall, pc_we=1.
- mem_ir=BEQZ, mem_cond=1 while id_ir has a hazard -> if_id_flush=1, id_ex_bubble=1, pc_we=1, flush_cnt=1, state RUN.
- HLT reaches id_ir -> HALT_DRAIN for 3 cycles, then halted=1. Pulse resume -> halted=0, if_id_flush=1 for 1 cycle, pc_we=1.
- HLT draining with mem_ir=J, mem_cond=1 in drain cycle 1 -> drain aborted, flush, state RUN, halted never asserts.
- Force hazard for 10 cycles (wb_ir held) -> stall_err=1 at 8 consecutive cycles, stall_cnt=10. Drop rst_n mid-stall -> counters 0, stall_err 0, outputs forced immediately without waiting for a clock edge.
